cond_exec_unit: RTL and testbench

Parametrised conditional-execution unit for the pipelined processor, placed in the execute (EX) stage. It holds `NUM_CTX` banked NZCV flag registers and evaluates the ARM condition field of the EX instruction against the bank selected by `ctx_i`. It gates flag, register, memory and PC writes with the result. Register and memory write enables travel through a `PIPE_DEPTH`-deep, stall/flush-aware pipe toward writeback.

---
 rtl/cond_exec_unit.sv | 162 ++++++++++++++++
 tb/tb_cond_exec_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_unit.sv
// -----------------------------------------------------------------------------
// cond_exec_unit
//
// Conditional-execution unit for the EX stage. It holds NUM_CTX banked NZCV
// flag registers, evaluates the ARM condition field of the EX instruction
// against the bank selected by ctx_i, and gates the flag, register, memory
// and PC writes with the result. Register/memory write enables and the valid
// bit travel through a PIPE_DEPTH-deep, stall/flush-aware pipe.
//
// Ports:
//   clk_i          in   clock
//   rst_i          in   asynchronous active-high reset
//   valid_i        in   EX holds a real instruction
//   cond_i         in   ARM condition field
//   ctx_i          in   flag bank read and written this cycle
//   alu_flags_i    in   ALU result flags {N,Z,C,V}
//   flag_write_i   in   bit1 updates {N,Z}, bit0 updates {C,V}
//   pcs_i          in   decoded PC write request
//   reg_write_i    in   decoded register write request
//   mem_write_i    in   decoded memory write request
//   stall_i        in   EX instruction held and re-presented next cycle
//   flush_i        in   EX instruction killed
//   flags_load_i   in   direct load of bank ctx_i (MSR / context restore)
//   flags_data_i   in   value for flags_load_i
//   pc_src_o       out  branch taken (combinational)
//   cond_ex_o      out  condition passed (combinational)
//   flags_o        out  current contents of bank ctx_i
//   reg_write_o    out  gated register write enable after PIPE_DEPTH stages
//   mem_write_o    out  gated memory write enable after PIPE_DEPTH stages
//   valid_o        out  gated valid after PIPE_DEPTH stages
// -----------------------------------------------------------------------------
module cond_exec_unit #(
  parameter int NUM_CTX    = 2,
  parameter int PIPE_DEPTH = 1,
  // Derived from NUM_CTX; not meant to be overridden.
  parameter int CW         = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [3:0]    cond_i,
  input  logic [CW-1:0] ctx_i,
  input  logic [3:0]    alu_flags_i,
  input  logic [1:0]    flag_write_i,
  input  logic          pcs_i,
  input  logic          reg_write_i,
  input  logic          mem_write_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          flags_load_i,
  input  logic [3:0]    flags_data_i,
  output logic          pc_src_o,
  output logic          cond_ex_o,
  output logic [3:0]    flags_o,
  output logic          reg_write_o,
  output logic          mem_write_o,
  output logic          valid_o
);

  // ARM condition evaluation; flags are ordered {N,Z,C,V}.
  function automatic logic f_cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'h0:    f_cond_pass = z;                  // EQ
      4'h1:    f_cond_pass = !z;                 // NE
      4'h2:    f_cond_pass = c;                  // CS
      4'h3:    f_cond_pass = !c;                 // CC
      4'h4:    f_cond_pass = n;                  // MI
      4'h5:    f_cond_pass = !n;                 // PL
      4'h6:    f_cond_pass = v;                  // VS
      4'h7:    f_cond_pass = !v;                 // VC
      4'h8:    f_cond_pass = c && !z;            // HI
      4'h9:    f_cond_pass = !c || z;            // LS
      4'hA:    f_cond_pass = (n == v);           // GE
      4'hB:    f_cond_pass = (n != v);           // LT
      4'hC:    f_cond_pass = !z && (n == v);     // GT
      4'hD:    f_cond_pass = z || (n != v);      // LE
      4'hE:    f_cond_pass = 1'b1;               // AL
      default: f_cond_pass = 1'b0;               // never
    endcase
  endfunction

  logic [3:0] r_bank [NUM_CTX];
  logic [3:0] w_flags;
  logic       w_cond_pass;
  logic       w_go;
  logic [2:0] w_stage_in;   // {valid, reg_write, mem_write}
  logic       w_advance;

  // Bank read. A ctx_i beyond NUM_CTX matches no bank and reads as zero.
  // NOTE: every variable written in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_flags = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (int'(ctx_i) == i) w_flags = r_bank[i];
    end
  end

  assign w_cond_pass = f_cond_pass(cond_i, w_flags);
  assign w_go        = valid_i && w_cond_pass && !stall_i && !flush_i;

  assign flags_o   = w_flags;
  assign cond_ex_o = w_cond_pass;
  assign pc_src_o  = pcs_i && w_go;

  // Flag banks. A direct load ignores go/stall/flush and wins over an ALU
  // update in the same cycle; an out-of-range ctx_i writes nothing.
  // NOTE: the bank array is a handful of flops, not a RAM, and must come out
  // of reset as all-zero, so every entry is cleared in the reset branch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CTX; i++) r_bank[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (int'(ctx_i) == i) begin
          if (flags_load_i) begin
            r_bank[i] <= flags_data_i;
          end else begin
            // NOTE: non-blocking assignments for all sequential state so every
            // flop samples pre-edge values regardless of statement order.
            if (flag_write_i[1] && w_go) r_bank[i][3:2] <= alu_flags_i[3:2];
            if (flag_write_i[0] && w_go) r_bank[i][1:0] <= alu_flags_i[1:0];
          end
        end
      end
    end
  end

  // A flushed instruction has go=0, so stage 1 naturally receives a bubble.
  assign w_stage_in = {w_go, reg_write_i && w_go, mem_write_i && w_go};
  // Flush overrides stall: the pipe moves on whenever the EX slot is killed.
  assign w_advance  = flush_i || !stall_i;

  generate
    if (PIPE_DEPTH == 0) begin : g_comb
      assign valid_o     = w_stage_in[2];
      assign reg_write_o = w_stage_in[1];
      assign mem_write_o = w_stage_in[0];
    end else begin : g_pipe
      logic [2:0] r_pipe [PIPE_DEPTH];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < PIPE_DEPTH; i++) r_pipe[i] <= '0;
        end else if (w_advance) begin
          r_pipe[0] <= w_stage_in;
          for (int i = 1; i < PIPE_DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign valid_o     = r_pipe[PIPE_DEPTH-1][2];
      assign reg_write_o = r_pipe[PIPE_DEPTH-1][1];
      assign mem_write_o = r_pipe[PIPE_DEPTH-1][0];
    end
  endgenerate

endmodule

// File: tb/tb_cond_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_cond_exec_unit
//
// Self-checking bench for cond_exec_unit with NUM_CTX=2, PIPE_DEPTH=2.
// A flag-bank model and a condition model predict the combinational outputs;
// expected pipe outputs are pushed to a queue as each instruction is driven
// and popped as the pipe advances, so the queue head is what the DUT must
// show on its registered outputs.
// -----------------------------------------------------------------------------
module tb_cond_exec_unit;

  localparam int NUM_CTX    = 2;
  localparam int PIPE_DEPTH = 2;
  localparam int CW         = 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [3:0]    cond_i;
  logic [CW-1:0] ctx_i;
  logic [3:0]    alu_flags_i;
  logic [1:0]    flag_write_i;
  logic          pcs_i;
  logic          reg_write_i;
  logic          mem_write_i;
  logic          stall_i;
  logic          flush_i;
  logic          flags_load_i;
  logic [3:0]    flags_data_i;
  logic          pc_src_o;
  logic          cond_ex_o;
  logic [3:0]    flags_o;
  logic          reg_write_o;
  logic          mem_write_o;
  logic          valid_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_bank [NUM_CTX];
  logic [2:0] sb_q [$];   // {valid, reg_write, mem_write}; head = DUT output

  always #5 clk = ~clk;

  cond_exec_unit #(
    .NUM_CTX    (NUM_CTX),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .cond_i       (cond_i),
    .ctx_i        (ctx_i),
    .alu_flags_i  (alu_flags_i),
    .flag_write_i (flag_write_i),
    .pcs_i        (pcs_i),
    .reg_write_i  (reg_write_i),
    .mem_write_i  (mem_write_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .flags_load_i (flags_load_i),
    .flags_data_i (flags_data_i),
    .pc_src_o     (pc_src_o),
    .cond_ex_o    (cond_ex_o),
    .flags_o      (flags_o),
    .reg_write_o  (reg_write_o),
    .mem_write_o  (mem_write_o),
    .valid_o      (valid_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Condition model: even codes pick a base test, odd codes invert it.
  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] & ~f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic idle_inputs();
    valid_i      = 1'b0;
    cond_i       = 4'h0;
    ctx_i        = '0;
    alu_flags_i  = 4'h0;
    flag_write_i = 2'b00;
    pcs_i        = 1'b0;
    reg_write_i  = 1'b0;
    mem_write_i  = 1'b0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    flags_load_i = 1'b0;
    flags_data_i = 4'h0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CTX; i++) m_bank[i] = 4'h0;
    sb_q.delete();
    for (int i = 0; i < PIPE_DEPTH; i++) sb_q.push_back(3'b000);
  endtask

  // One clock cycle: inputs were driven after the previous falling edge.
  task automatic cycle();
    logic [3:0] cur;
    logic       pass;
    logic       go;
    #1;
    cur  = m_bank[ctx_i];
    pass = m_cond(cond_i, cur);
    go   = valid_i & pass & ~stall_i & ~flush_i;
    check("flags_o",     32'(flags_o),     32'(cur));
    check("cond_ex_o",   32'(cond_ex_o),   32'(pass));
    check("pc_src_o",    32'(pc_src_o),    32'(pcs_i & go));
    check("valid_o",     32'(valid_o),     32'(sb_q[0][2]));
    check("reg_write_o", 32'(reg_write_o), 32'(sb_q[0][1]));
    check("mem_write_o", 32'(mem_write_o), 32'(sb_q[0][0]));
    @(posedge clk);
    if (flags_load_i) begin
      m_bank[ctx_i] = flags_data_i;
    end else begin
      if (flag_write_i[1] && go) m_bank[ctx_i][3:2] = alu_flags_i[3:2];
      if (flag_write_i[0] && go) m_bank[ctx_i][1:0] = alu_flags_i[1:0];
    end
    if (flush_i || !stall_i) begin
      void'(sb_q.pop_front());
      sb_q.push_back({go, reg_write_i & go, mem_write_i & go});
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] saved;
    int         pulses;

    idle_inputs();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    // Reset state
    #1;
    check("rst_flags", 32'(flags_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    repeat (2) cycle();

    // Partial flag write: {N,Z} only
    valid_i = 1'b1; cond_i = 4'hE; alu_flags_i = 4'hF; flag_write_i = 2'b10;
    cycle();
    check("partial_nz", 32'(flags_o), 32'hC);
    cond_i = 4'h1; flag_write_i = 2'b01;
    #1;
    check("partial_ne_fail", 32'(cond_ex_o), 32'h0);
    cycle();
    check("partial_cv_hold", 32'(flags_o), 32'hC);
    idle_inputs();
    cycle();

    // Condition sweep: every flag value against every code
    for (int f = 0; f < 16; f++) begin
      idle_inputs();
      flags_load_i = 1'b1; flags_data_i = 4'(f);
      cycle();
      flags_load_i = 1'b0;
      for (int c = 0; c < 16; c++) begin
        cond_i = 4'(c);
        #1;
        check($sformatf("sweep_f%0h_c%0h", f, c), 32'(cond_ex_o), 32'(m_cond(4'(c), 4'(f))));
      end
    end
    idle_inputs();
    cycle();

    // Banking
    flags_load_i = 1'b1; ctx_i = 1'b0; flags_data_i = 4'b0100;
    cycle();
    ctx_i = 1'b1; flags_data_i = 4'b0010;
    cycle();
    idle_inputs();
    cond_i = 4'h0; ctx_i = 1'b0;
    #1;
    check("bank0_eq", 32'(cond_ex_o), 32'h1);
    ctx_i = 1'b1;
    #1;
    check("bank1_eq", 32'(cond_ex_o), 32'h0);
    flags_load_i = 1'b1; flags_data_i = 4'hF;
    cycle();
    idle_inputs();
    ctx_i = 1'b0;
    #1;
    check("bank0_isolated", 32'(flags_o), 32'h4);
    cycle();

    // Stall for three cycles, then release
    saved = m_bank[0];
    valid_i = 1'b1; cond_i = 4'hE; reg_write_i = 1'b1; pcs_i = 1'b1;
    flag_write_i = 2'b11; alu_flags_i = 4'b1011; stall_i = 1'b1;
    repeat (3) begin
      #1;
      check("stall_pc_src", 32'(pc_src_o), 32'h0);
      cycle();
      check("stall_no_rw", 32'(reg_write_o), 32'h0);
      check("stall_flags_hold", 32'(flags_o), 32'(saved));
    end
    stall_i = 1'b0;
    #1;
    check("release_pc_src", 32'(pc_src_o), 32'h1);
    cycle();
    check("release_flags", 32'(flags_o), 32'hB);
    idle_inputs();
    pulses = 0;
    check("release_edge1_rw", 32'(reg_write_o), 32'h0);
    cycle();
    check("release_edge2_rw", 32'(reg_write_o), 32'h1);
    pulses += int'(reg_write_o);
    repeat (3) begin
      cycle();
      pulses += int'(reg_write_o);
    end
    check("release_rw_once", 32'(pulses), 32'd1);

    // Stall and flush together: flush wins, nothing takes effect
    saved = m_bank[0];
    valid_i = 1'b1; cond_i = 4'hE; reg_write_i = 1'b1; pcs_i = 1'b1;
    flag_write_i = 2'b11; alu_flags_i = 4'h0; stall_i = 1'b1; flush_i = 1'b1;
    #1;
    check("flush_pc_src", 32'(pc_src_o), 32'h0);
    cycle();
    idle_inputs();
    check("flush_flags_hold", 32'(flags_o), 32'(saved));
    repeat (3) cycle();

    // Load priority over a same-cycle passing ALU write
    valid_i = 1'b1; cond_i = 4'hE; flag_write_i = 2'b11; alu_flags_i = 4'b1110;
    flags_load_i = 1'b1; flags_data_i = 4'b0001;
    cycle();
    idle_inputs();
    check("load_priority", 32'(flags_o), 32'h1);
    cycle();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      valid_i      = 1'($urandom_range(0, 3) != 0);
      cond_i       = 4'($urandom);
      ctx_i        = 1'($urandom);
      alu_flags_i  = 4'($urandom);
      flag_write_i = 2'($urandom);
      pcs_i        = 1'($urandom);
      reg_write_i  = 1'($urandom);
      mem_write_i  = 1'($urandom);
      stall_i      = 1'($urandom_range(0, 3) == 0);
      flush_i      = 1'($urandom_range(0, 9) == 0);
      flags_load_i = 1'($urandom_range(0, 9) == 0);
      flags_data_i = 4'($urandom);
      cycle();
    end

    // Asynchronous reset mid-cycle with the pipe full
    idle_inputs();
    valid_i = 1'b1; cond_i = 4'hE; reg_write_i = 1'b1; mem_write_i = 1'b1;
    repeat (PIPE_DEPTH) cycle();
    check("full_before_rst", 32'(valid_o), 32'h1);
    idle_inputs();
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    check("rst_async_valid", 32'(valid_o),     32'h0);
    check("rst_async_rw",    32'(reg_write_o), 32'h0);
    check("rst_async_mw",    32'(mem_write_o), 32'h0);
    check("rst_async_flags", 32'(flags_o),     32'h0);
    cond_i = 4'h0;
    #1;
    check("rst_eq", 32'(cond_ex_o), 32'h0);
    cond_i = 4'h1;
    #1;
    check("rst_ne", 32'(cond_ex_o), 32'h1);
    ctx_i = 1'b1;
    #1;
    check("rst_bank1", 32'(flags_o), 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    idle_inputs();
    valid_i = 1'b1; cond_i = 4'hE; mem_write_i = 1'b1;
    cycle();
    idle_inputs();
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
